// File: rtl/game_pkg.sv
// Shared types and BCD helpers for the Flappy game controller.
// Holds the game state encoding and the 4-digit BCD score arithmetic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } gameState_t;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

  // Saturating BCD increment with per-digit carry.
  function automatic logic [15:0] bcdInc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    if (value != BCD_MAX) begin
      for (int d = 0; d < BCD_DIGITS; d++) begin
        if (carry) begin
          if (value[d*4 +: 4] == 4'd9) begin
            result[d*4 +: 4] = 4'd0;
          end else begin
            result[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
    return result;
  endfunction

  // a > b, comparing the most significant digit first.
  function automatic logic bcdGreater(input logic [15:0] a, input logic [15:0] b);
    logic decided;
    logic greater;
    decided = 1'b0;
    greater = 1'b0;
    for (int d = BCD_DIGITS - 1; d >= 0; d--) begin
      if (!decided && (a[d*4 +: 4] != b[d*4 +: 4])) begin
        decided = 1'b1;
        greater = (a[d*4 +: 4] > b[d*4 +: 4]);
      end
    end
    return greater;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each debounced rising edge (Press rises together with Level).
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnIn,
  output logic Level,
  output logic Press
);

  localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          syncMeta;
  logic          syncLevel;
  logic [CW-1:0] stableCnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      syncMeta  <= 1'b0;
      syncLevel <= 1'b0;
      stableCnt <= '0;
      Level     <= 1'b0;
      Press     <= 1'b0;
    end else begin
      syncMeta  <= BtnIn;
      syncLevel <= syncMeta;
      Press     <= 1'b0;
      if (syncLevel == Level) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_LAST) begin
        stableCnt <= '0;
        Level     <= syncLevel;
        Press     <= syncLevel;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: frame tick, IDLE/PLAY/DYING/OVER FSM, BCD score and high score.
// Optional attract-mode bird bobbing in IDLE is enabled with `define ATTRACT_MODE_EN.
module flappy_game_ctrl
  import game_pkg::*;
#(
  parameter int FRAME_DIV    = 1666667,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int DEATH_FRAMES = 60
`ifdef ATTRACT_MODE_EN
  ,
  parameter int AUTO_FLAP_FRAMES = 32
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnFlap,
  input  logic        Collision,
  input  logic        PipePassed,
  output logic        FrameTick,
  output logic [1:0]  GameState,
  output logic        PipeEn,
  output logic        BirdEn,
  output logic        FlapPulse,
  output logic        PipeClr,
  output logic [15:0] Score,
  output logic [15:0] HighScore
);

  localparam int            FW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam int            DW         = $clog2(DEATH_FRAMES + 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

  logic          press;
  logic          unusedBtnLevel;
  logic [FW-1:0] frameCnt;
  gameState_t    stateReg, stateNext;
  logic [DW-1:0] deathCnt, deathNext;
  logic [15:0]   scoreNext, highNext;
  logic          pipeEnNext, birdEnNext, flapNext, pipeClrNext;
  logic          autoFlap, idleBirdEn;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) uDebounce (
    .Clk  (Clk),
    .Reset(Reset),
    .BtnIn(BtnFlap),
    .Level(unusedBtnLevel),
    .Press(press)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frameCnt  <= '0;
      FrameTick <= 1'b0;
    end else begin
      FrameTick <= (frameCnt == FRAME_LAST);
      frameCnt  <= (frameCnt == FRAME_LAST) ? '0 : frameCnt + 1'b1;
    end
  end

`ifdef ATTRACT_MODE_EN
  localparam int            AW        = (AUTO_FLAP_FRAMES > 1) ? $clog2(AUTO_FLAP_FRAMES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FLAP_FRAMES - 1);
  logic [AW-1:0] autoCnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      autoCnt <= '0;
    end else if (stateReg != IDLE) begin
      autoCnt <= '0;
    end else if (FrameTick) begin
      autoCnt <= (autoCnt == AUTO_LAST) ? '0 : autoCnt + 1'b1;
    end
  end

  assign autoFlap   = (stateReg == IDLE) && FrameTick && (autoCnt == AUTO_LAST);
  assign idleBirdEn = 1'b1;
`else
  assign autoFlap   = 1'b0;
  assign idleBirdEn = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateReg  <= IDLE;
      deathCnt  <= '0;
      Score     <= '0;
      HighScore <= '0;
      PipeEn    <= 1'b0;
      BirdEn    <= 1'b0;
      FlapPulse <= 1'b0;
      PipeClr   <= 1'b1;
    end else begin
      stateReg  <= stateNext;
      deathCnt  <= deathNext;
      Score     <= scoreNext;
      HighScore <= highNext;
      PipeEn    <= pipeEnNext;
      BirdEn    <= birdEnNext;
      FlapPulse <= flapNext;
      PipeClr   <= pipeClrNext;
    end
  end

  assign GameState = stateReg;

  always_comb begin
    stateNext = stateReg;
    scoreNext = Score;
    highNext  = HighScore;
    deathNext = '0;
    case (stateReg)
      IDLE: begin
        if (press) begin
          stateNext = PLAY;
          scoreNext = '0;
        end
      end
      PLAY: begin
        // A collision in the same cycle as a pipe pass forfeits the point.
        if (Collision) begin
          stateNext = DYING;
        end else if (PipePassed) begin
          scoreNext = bcdInc(Score);
        end
      end
      DYING: begin
        deathNext = FrameTick ? deathCnt + 1'b1 : deathCnt;
        if (FrameTick && (deathCnt == DEATH_LAST)) begin
          stateNext = OVER;
          if (bcdGreater(Score, HighScore)) begin
            highNext = Score;
          end
        end
      end
      OVER: begin
        if (press) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    pipeClrNext = (stateNext == IDLE);
    pipeEnNext  = (stateNext == PLAY);
    birdEnNext  = (stateNext == PLAY) || (stateNext == DYING) ||
                  ((stateNext == IDLE) && idleBirdEn);
    flapNext    = (press && (stateNext == PLAY)) || (autoFlap && (stateNext == IDLE));
  end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: table-driven games, randomized games
// against an integer score model, and hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btnFlap;
  logic        collision;
  logic        pipePassed;
  logic        frameTick;
  logic [1:0]  gameState;
  logic        pipeEn;
  logic        birdEn;
  logic        flapPulse;
  logic        pipeClr;
  logic [15:0] score;
  logic [15:0] highScore;

  always #5 clk = ~clk;

  flappy_game_ctrl #(
    .FRAME_DIV   (4),
    .DEBOUNCE_CYC(3),
    .DEATH_FRAMES(2)
`ifdef ATTRACT_MODE_EN
    ,
    .AUTO_FLAP_FRAMES(2)
`endif
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .BtnFlap   (btnFlap),
    .Collision (collision),
    .PipePassed(pipePassed),
    .FrameTick (frameTick),
    .GameState (gameState),
    .PipeEn    (pipeEn),
    .BirdEn    (birdEn),
    .FlapPulse (flapPulse),
    .PipeClr   (pipeClr),
    .Score     (score),
    .HighScore (highScore)
  );

  int checks   = 0;
  int failures = 0;

  // Event counters, sampled on the clock edge (values of the cycle just ended).
  int flapIdle   = 0;
  int flapPlay   = 0;
  int flapOther  = 0;
  int dyingTicks = 0;

  always @(posedge clk) begin
    if (flapPulse) begin
      if (gameState == 2'd0)      flapIdle  <= flapIdle + 1;
      else if (gameState == 2'd1) flapPlay  <= flapPlay + 1;
      else                        flapOther <= flapOther + 1;
    end
    if (frameTick && gameState == 2'd2) dyingTicks <= dyingTicks + 1;
  end

  typedef struct {
    int          passes;
    logic [15:0] expScore;
    logic [15:0] expHigh;
  } game_vec_t;

  game_vec_t vecs[6];
  int        highModel = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic waitState(input string name, input logic [1:0] target, input int limit);
    int k;
    k = 0;
    while (gameState !== target && k < limit) begin
      step(1);
      k++;
    end
    check(name, {30'd0, gameState}, {30'd0, target});
  endtask

  task automatic waitTick(input string name, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (frameTick !== 1'b1 && cycles < 50);
    if (frameTick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s no FrameTick within %0d cycles", name, cycles);
    end
  endtask

  task automatic pressButton(input int hold);
    btnFlap = 1'b1;
    step(hold);
    btnFlap = 1'b0;
    step(8);
  endtask

  function automatic logic [15:0] toBcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic passPipes(input int n);
    repeat (n) begin
      pipePassed = 1'b1;
      step(1);
      pipePassed = 1'b0;
      step(1);
    end
  endtask

  task automatic startGame(input string name);
    int fp0;
    fp0 = flapPlay;
    pressButton(10);
    check({name, "_state_play"}, {30'd0, gameState}, 32'd1);
    check({name, "_score_clr"}, {16'd0, score}, 32'd0);
    check({name, "_start_flap"}, flapPlay - fp0, 32'd1);
  endtask

  // Collision coincides with a pipe pass; a press is injected mid-DYING.
  task automatic finishGame(input string name, input logic [15:0] expScore, input logic [15:0] expHigh);
    int dt0, fo0;
    dt0 = dyingTicks;
    fo0 = flapOther;
    btnFlap = 1'b1;
    step(2);
    collision  = 1'b1;
    pipePassed = 1'b1;
    step(1);
    collision  = 1'b0;
    pipePassed = 1'b0;
    check({name, "_state_dying"}, {30'd0, gameState}, 32'd2);
    check({name, "_score_at_death"}, {16'd0, score}, {16'd0, expScore});
    waitState({name, "_state_over"}, 2'd3, 40);
    btnFlap = 1'b0;
    step(6);
    check({name, "_dying_ticks"}, dyingTicks - dt0, 32'd2);
    check({name, "_no_dying_flap"}, flapOther - fo0, 32'd0);
    check({name, "_still_over"}, {30'd0, gameState}, 32'd3);
    check({name, "_high"}, {16'd0, highScore}, {16'd0, expHigh});
    check({name, "_over_en"}, {30'd0, pipeEn, birdEn}, 32'd0);
    pressButton(10);
    check({name, "_back_idle"}, {30'd0, gameState}, 32'd0);
    check({name, "_idle_clr"}, {31'd0, pipeClr}, 32'd1);
    check({name, "_score_held"}, {16'd0, score}, {16'd0, expScore});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int f0, fp0;
    int n;
    int expIdleFlaps;
    logic expIdleBird;

`ifdef ATTRACT_MODE_EN
    expIdleFlaps = 4;
    expIdleBird  = 1'b1;
`else
    expIdleFlaps = 0;
    expIdleBird  = 1'b0;
`endif

    vecs[0] = '{3,  16'h0003, 16'h0003};
    vecs[1] = '{5,  16'h0005, 16'h0005};
    vecs[2] = '{7,  16'h0007, 16'h0007};
    vecs[3] = '{5,  16'h0005, 16'h0007};
    vecs[4] = '{12, 16'h0012, 16'h0012};
    vecs[5] = '{10, 16'h0010, 16'h0012};

    reset      = 1'b1;
    btnFlap    = 1'b0;
    collision  = 1'b0;
    pipePassed = 1'b0;
    step(3);
    check("rst_state", {30'd0, gameState}, 32'd0);
    check("rst_score", {16'd0, score}, 32'd0);
    check("rst_high", {16'd0, highScore}, 32'd0);
    check("rst_pipeclr", {31'd0, pipeClr}, 32'd1);
    check("rst_enables", {30'd0, pipeEn, birdEn}, 32'd0);
    check("rst_flap_tick", {30'd0, flapPulse, frameTick}, 32'd0);
    reset = 1'b0;
    step(1);

    waitTick("tick_sync", cyc);
    for (int i = 0; i < 3; i++) begin
      waitTick("tick_period", cyc);
      check("tick_period", cyc, 32'd4);
    end

    // Eight consecutive frame ticks spent in IDLE.
    waitTick("idle_sync", cyc);
    f0 = flapIdle;
    for (int i = 0; i < 8; i++) waitTick("idle_window", cyc);
    check("idle_auto_flaps", flapIdle - f0, expIdleFlaps);
    check("idle_birden", {31'd0, birdEn}, {31'd0, expIdleBird});
    check("idle_pipeen", {31'd0, pipeEn}, 32'd0);
    check("idle_pipeclr", {31'd0, pipeClr}, 32'd1);

    fp0 = flapPlay;
    btnFlap = 1'b1;
    step(2);
    btnFlap = 1'b0;
    step(8);
    check("glitch_state", {30'd0, gameState}, 32'd0);
    check("glitch_flap", flapPlay - fp0, 32'd0);

    startGame("first");
    check("first_play_en", {29'd0, pipeEn, birdEn, pipeClr}, 32'b110);
    finishGame("first", 16'h0000, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      $display("table game %0d passes=%0d", i, vecs[i].passes);
      startGame("table");
      passPipes(vecs[i].passes);
      check("table_score", {16'd0, score}, {16'd0, vecs[i].expScore});
      finishGame("table", vecs[i].expScore, vecs[i].expHigh);
      if (vecs[i].passes > highModel) highModel = vecs[i].passes;
    end

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, 60);
      if (n > highModel) highModel = n;
      $display("random game %0d passes=%0d", i, n);
      startGame("rand");
      passPipes(n);
      check("rand_score", {16'd0, score}, {16'd0, toBcd(n)});
      finishGame("rand", toBcd(n), toBcd(highModel));
    end

    startGame("sat");
    passPipes(100);
    check("sat_0100", {16'd0, score}, 32'h0100);
    passPipes(9898);
    check("sat_9998", {16'd0, score}, 32'h9998);
    passPipes(3);
    check("sat_9999", {16'd0, score}, 32'h9999);
    finishGame("sat", 16'h9999, 16'h9999);

    startGame("rstmid");
    passPipes(42);
    check("rstmid_score", {16'd0, score}, 32'h0042);
    reset = 1'b1;
    #1;
    check("rstmid_state", {30'd0, gameState}, 32'd0);
    check("rstmid_score0", {16'd0, score}, 32'd0);
    check("rstmid_high0", {16'd0, highScore}, 32'd0);
    check("rstmid_pipeclr", {31'd0, pipeClr}, 32'd1);
    check("rstmid_pipeen", {31'd0, pipeEn}, 32'd0);
    step(2);
    reset = 1'b0;
    step(2);
    check("rstmid_after", {30'd0, gameState}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
